// File: rtl/sreg_rr_sched_if.sv
// ---------------------------------------------------------------------------
// sreg_rr_sched_if
//   Handshake bundle between the requester fabric / downstream consumer and
//   the sreg_rr_sched scheduler.
//
//   Request side : req_valid[N_REQ], req_data[N_REQ*WIDTH] (requester i at
//                  bits [i*WIDTH +: WIDTH]), req_ready[N_REQ] (one-hot grant)
//   Output side  : out_valid, out_data[WIDTH], out_id[IDW], out_ready
//
//   Modports
//     master : the fabric/consumer side (drives requests and out_ready)
//     slave  : the scheduler side (drives grants and the output entry)
// ---------------------------------------------------------------------------
interface sreg_rr_sched_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic [IDW-1:0]         out_id;
    logic                   out_ready;

    modport master (
        output req_valid,
        output req_data,
        output out_ready,
        input  req_ready,
        input  out_valid,
        input  out_data,
        input  out_id
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  out_ready,
        output req_ready,
        output out_valid,
        output out_data,
        output out_id
    );
endinterface

// File: rtl/sreg_rr_sched.sv
// ---------------------------------------------------------------------------
// sreg_rr_sched
//   Round-robin scheduler sharing one external DEPTH-stage shift-register
//   delay line among N_REQ requesters. The delay line carries only data; this
//   block tracks a valid bit and requester ID per stage so that stale stage
//   contents (stage 0 is never cleared by sclr) are never reported.
//
//   Ports
//     clk, rst_n  : clock (rising edge), asynchronous active-low reset
//     bus         : sreg_rr_sched_if.slave (requests, grants, tagged output)
//     flush       : discard every in-flight entry (same-cycle effect on
//                   outputs, valid bits cleared at the next edge)
//     drain       : stop accepting and let the pipeline empty
//     drain_done  : one-cycle registered pulse in the final DRAIN cycle
//     sr_ce/sr_sclr/sr_d/sr_q : control and data of the external delay line
//     busy        : pipeline holds a valid entry or state is not RUN
// ---------------------------------------------------------------------------
module sreg_rr_sched #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    sreg_rr_sched_if.slave   bus,
    input  logic             flush,
    input  logic             drain,
    output logic             drain_done,
    output logic             sr_ce,
    output logic             sr_sclr,
    output logic [WIDTH-1:0] sr_d,
    input  logic [WIDTH-1:0] sr_q,
    output logic             busy
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]                 state_reg, state_next;
    logic [DEPTH-1:0]           vld_reg, vld_next;
    logic [DEPTH-1:0][IDW-1:0]  id_reg, id_next;
    logic [IDW-1:0]             ptr_reg, ptr_next;
    logic                       drain_done_reg, drain_done_next;

    logic                       adv;
    logic                       grant_en;
    logic                       grant_any;
    logic [IDW-1:0]             winner;
    logic [WIDTH-1:0]           req_word [N_REQ];
    logic [IDW-1:0]             cand_idx [N_REQ];

    // (base + k) mod N_REQ for base < N_REQ and 1 <= k <= N_REQ; a single
    // conditional subtraction is enough for that range.
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        return sum[IDW-1:0];
    endfunction

    // Unpack request words and precompute the circular search order that
    // starts just after the last winner.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign req_word[gi] = bus.req_data[gi*WIDTH +: WIDTH];
            assign cand_idx[gi] = rr_index(ptr_reg, gi + 1);
        end
    endgenerate

    // The pipeline moves whenever the output stage is empty or being taken.
    // flush freezes the delay line for the cycle in which it clears it.
    assign adv = (state_reg != ST_IDLE) && !flush &&
                 (!vld_reg[DEPTH-1] || bus.out_ready);

    // New entries only in RUN, and not in the cycle drain is raised, so that
    // nothing is accepted from the drain request onwards.
    assign grant_en = (state_reg == ST_RUN) && adv && !drain;

    // Walk the candidates from farthest to nearest so the nearest valid
    // requester after ptr is the one left in winner.
    always_comb begin
        grant_any = 1'b0;
        winner    = '0;
        if (grant_en) begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                if (bus.req_valid[cand_idx[k]]) begin
                    grant_any = 1'b1;
                    winner    = cand_idx[k];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign bus.req_ready[gi] = grant_any && (winner == IDW'(gi));
        end
    endgenerate

    // Control state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  state_next = ST_RUN;
            ST_RUN:   if (drain && !flush) state_next = ST_DRAIN;
            ST_DRAIN: if (vld_reg == '0) state_next = ST_RUN;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Per-stage valid/ID shadow of the delay line
    always_comb begin
        vld_next = vld_reg;
        id_next  = id_reg;
        if (flush) begin
            vld_next = '0;
        end else if (adv) begin
            vld_next = {vld_reg[DEPTH-2:0], grant_any};
            id_next  = {id_reg[DEPTH-2:0], winner};
        end
    end

    assign ptr_next = grant_any ? winner : ptr_reg;

    // Registered so that it is high exactly in the DRAIN cycle that sees an
    // empty pipeline, which is also the last DRAIN cycle.
    assign drain_done_next = (state_next == ST_DRAIN) && (vld_next == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            vld_reg        <= '0;
            id_reg         <= '0;
            ptr_reg        <= IDW'(N_REQ - 1);
            drain_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            vld_reg        <= vld_next;
            id_reg         <= id_next;
            ptr_reg        <= ptr_next;
            drain_done_reg <= drain_done_next;
        end
    end

    // Delay line control: IDLE doubles as the startup clear.
    assign sr_ce   = adv;
    assign sr_sclr = flush || (state_reg == ST_IDLE);
    assign sr_d    = grant_any ? req_word[winner] : '0;

    assign bus.out_valid = vld_reg[DEPTH-1] && !flush && (state_reg != ST_IDLE);
    assign bus.out_data  = sr_q;
    assign bus.out_id    = id_reg[DEPTH-1];

    assign drain_done = drain_done_reg;
    assign busy       = (vld_reg != '0) || (state_reg != ST_RUN);
endmodule
